product_serializer: RTL and testbench



---
 rtl/product_serializer.sv | 163 ++++++++++++++++
 tb/tb_product_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_serializer.sv
// Product serializer: FIFO of (product, mode) pairs streamed out as 32-bit words, LSW first.
// Optional SER_PARITY_EN adds out_parity, parity_inj and parity_err_inj_ack.
module product_serializer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [127:0]             in_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [1:0]               out_mode,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         words_sent
`ifdef SER_PARITY_EN
    ,
    input  logic                     parity_inj,
    output logic                     out_parity,
    output logic                     parity_err_inj_ack
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [1:0]        out_mode_q, out_mode_d;
    logic [CNT_W-1:0]  words_q, words_d;

    logic [127:0]      mem_product [DEPTH];
    logic [1:0]        mem_mode    [DEPTH];

    logic              push, accept, pop;
    logic [127:0]      head_product;
    logic [1:0]        head_mode;

    function automatic logic [1:0] last_idx(input logic [1:0] mode);
        case (mode)
            2'd2:    return 2'd2;
            2'd3:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    assign in_ready = (count_q != CntW'(DEPTH));
    assign out_valid = (state_q == StStream);
    assign push = in_valid && in_ready;
    assign accept = out_valid && out_ready;
    assign pop = accept && out_last_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d = idx_q;
        words_d = words_q;
        out_data_d = out_data_q;
        out_mode_d = out_mode_q;
        out_last_d = 1'b0;
        head_product = '0;
        head_mode = '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (accept) begin
            if (words_q != '1) begin
                words_d = words_q + CNT_W'(1);
            end
            if (out_last_q) begin
                idx_d = 2'd0;
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        count_d = count_q + CntW'(push) - CntW'(pop);
        state_d = (count_d != '0) ? StStream : StIdle;

        // When the FIFO drains to empty on this edge the new head is the entry being pushed.
        if (push && (count_q == CntW'(pop))) begin
            head_product = in_product;
            head_mode = in_mode;
        end else begin
            head_product = mem_product[rd_ptr_d];
            head_mode = mem_mode[rd_ptr_d];
        end

        if (state_d == StStream) begin
            out_data_d = head_product[{idx_d, 5'd0} +: 32];
            out_mode_d = head_mode;
            out_last_d = (idx_d == last_idx(head_mode));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            idx_q <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_mode_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            idx_q <= idx_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_mode_q <= out_mode_d;
            words_q <= words_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_product[wr_ptr_q] <= in_product;
            mem_mode[wr_ptr_q] <= in_mode;
        end
    end

    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign out_mode = out_mode_q;
    assign fifo_count = count_q;
    assign words_sent = words_q;

`ifdef SER_PARITY_EN
    logic parity_q, inj_ack_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
            inj_ack_q <= 1'b0;
        end else begin
            parity_q <= ^out_data_d;
            inj_ack_q <= accept && parity_inj;
        end
    end

    // Injection flips the parity of the word currently on the port.
    assign out_parity = parity_q ^ parity_inj;
    assign parity_err_inj_ack = inj_ack_q;
`endif

endmodule

// File: tb/tb_product_serializer.sv
// Directed self-checking bench for product_serializer; a second instance with a 2-bit
// counter checks words_sent saturation.
module tb_product_serializer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready, in_ready_s;
    logic [1:0]   in_mode = 2'd0;
    logic [127:0] in_product = '0;
    logic         out_valid, out_valid_s;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data, out_data_s;
    logic         out_last, out_last_s;
    logic [1:0]   out_mode, out_mode_s;
    logic [2:0]   fifo_count, fifo_count_s;
    logic [15:0]  words_sent;
    logic [1:0]   words_sent_s;
`ifdef SER_PARITY_EN
    logic parity_inj = 1'b0;
    logic out_parity, out_parity_s, inj_ack, inj_ack_s;
`endif

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    product_serializer #(.DEPTH(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_product(in_product), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_mode(out_mode), .fifo_count(fifo_count), .words_sent(words_sent)
`ifdef SER_PARITY_EN
        , .parity_inj(parity_inj), .out_parity(out_parity), .parity_err_inj_ack(inj_ack)
`endif
    );

    product_serializer #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_mode(in_mode), .in_product(in_product), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_last(out_last_s),
        .out_mode(out_mode_s), .fifo_count(fifo_count_s), .words_sent(words_sent_s)
`ifdef SER_PARITY_EN
        , .parity_inj(parity_inj), .out_parity(out_parity_s), .parity_err_inj_ack(inj_ack_s)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] prod3(input int k);
        logic [31:0] b;
        b = 32'hA000_0000 | 32'(k << 4);
        return {32'hDEAD_BEEF, b | 32'd2, b | 32'd1, b};
    endfunction

    initial begin
        logic [31:0] exp_w [4];
        logic clr;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_words", words_sent, 0);
        reset = 1'b0;

        // Mode 0: two words, first visible right after the push edge
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = 2'd0;
        in_product = 128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0;
        @(negedge clock);
        in_valid = 1'b0;
        chk("m0_w0_valid", out_valid, 1);
        chk("m0_w0_data", out_data, 32'h9ABC_DEF0);
        chk("m0_w0_last", out_last, 0);
        chk("m0_count", fifo_count, 1);
        @(negedge clock);
        chk("m0_w1_data", out_data, 32'h1234_5678);
        chk("m0_w1_last", out_last, 1);
        @(negedge clock);
        chk("m0_idle_valid", out_valid, 0);
        chk("m0_idle_last", out_last, 0);
        chk("m0_idle_hold", out_data, 32'h1234_5678);
        chk("m0_words", words_sent, 2);
        chk("m0_count_empty", fifo_count, 0);
        chk("sat_words_2", words_sent_s, 2);

        // Mode 3: four words LSW first
        exp_w = '{32'hCCDD_EEFF, 32'h8899_AABB, 32'h4455_6677, 32'h0011_2233};
        in_valid = 1'b1;
        in_mode = 2'd3;
        in_product = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m3_w%0d_data", i), out_data, exp_w[i]);
            chk($sformatf("m3_w%0d_last", i), out_last, (i == 3));
            chk($sformatf("m3_w%0d_mode", i), out_mode, 3);
            @(negedge clock);
        end
        chk("m3_idle", out_valid, 0);
        chk("m3_words", words_sent, 6);
        chk("sat_words_3", words_sent_s, 3);

        // Fill with sink stalled, 5th entry held back by in_ready
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fill%0d_ready", k), in_ready, 1);
            in_valid = 1'b1;
            in_mode = 2'd2;
            in_product = prod3(k);
            @(negedge clock);
        end
        chk("full_ready", in_ready, 0);
        chk("full_count", fifo_count, 4);
        in_product = prod3(4);
        repeat (2) @(negedge clock);
        chk("full_hold_count", fifo_count, 4);
        chk("full_hold_ready", in_ready, 0);
        chk("full_hold_data", out_data, 32'hA000_0000);
        chk("full_hold_words", words_sent, 6);
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (clr) begin
                in_valid = 1'b0;
                clr = 1'b0;
            end
            if (in_valid && in_ready) clr = 1'b1;
            chk($sformatf("drain%0d_valid", i), out_valid, 1);
            chk($sformatf("drain%0d_data", i), out_data,
                32'hA000_0000 | 32'((i / 3) << 4) | 32'(i % 3));
            chk($sformatf("drain%0d_last", i), out_last, (i % 3 == 2));
            @(negedge clock);
        end
        chk("drain_idle", out_valid, 0);
        chk("drain_count", fifo_count, 0);
        chk("drain_words", words_sent, 21);

        // Stall on the second word of a mode-2 product
        in_valid = 1'b1;
        in_mode = 2'd2;
        in_product = 128'hFFFF_FFFF_3333_3333_2222_2222_1111_1111;
        @(negedge clock);
        in_valid = 1'b0;
        chk("stall_w0", out_data, 32'h1111_1111);
        @(negedge clock);
        chk("stall_w1", out_data, 32'h2222_2222);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_data", i), out_data, 32'h2222_2222);
            chk($sformatf("stall%0d_last", i), out_last, 0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("stall_resume", out_data, 32'h3333_3333);
        chk("stall_resume_last", out_last, 1);
        @(negedge clock);
        chk("stall_idle", out_valid, 0);
        chk("stall_words", words_sent, 24);

        // Reset mid-stream with two entries queued behind the head
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 2'd3;
        in_product = 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0;
        @(negedge clock);
        in_product = 128'h0000_00B3_0000_00B2_0000_00B1_0000_00B0;
        @(negedge clock);
        in_product = 128'h0000_00C3_0000_00C2_0000_00C1_0000_00C0;
        @(negedge clock);
        in_valid = 1'b0;
        chk("mid_count", fifo_count, 3);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("mid_w1", out_data, 32'h0000_00A1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_words", words_sent, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("sat_rst_words", words_sent_s, 0);
        @(negedge clock);
        chk("mid_no_resume", out_valid, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mode = 2'd0;
        in_product = 128'hFFFF_FFFF_FFFF_FFFF_CAFE_F00D_0BAD_BEEF;
        @(negedge clock);
        in_valid = 1'b0;
        chk("post_w0", out_data, 32'h0BAD_BEEF);
        chk("post_w0_mode", out_mode, 0);
        @(negedge clock);
        chk("post_w1", out_data, 32'hCAFE_F00D);
        chk("post_w1_last", out_last, 1);
        @(negedge clock);
        chk("post_idle", out_valid, 0);
        chk("post_words", words_sent, 2);

`ifdef SER_PARITY_EN
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_product = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
        @(negedge clock);
        in_valid = 1'b0;
        chk("par_plain", out_parity, 1);
        parity_inj = 1'b1;
        #1;
        chk("par_inj", out_parity, 0);
        out_ready = 1'b1;
        @(negedge clock);
        parity_inj = 1'b0;
        out_ready = 1'b0;
        chk("par_ack", inj_ack, 1);
        chk("par_w1", out_parity, 0);
        @(negedge clock);
        chk("par_ack_pulse", inj_ack, 0);
        out_ready = 1'b1;
        @(negedge clock);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
